// File: rtl/axi4_mem_responder.sv
// ---------------------------------------------------------------------------
// axi4_mem_responder
//   AXI4 subordinate backed by an internal flop-array memory. Serves exactly one
//   transaction at a time (IDLE -> WDATA -> WRESP -> IDLE or IDLE -> RDATA -> IDLE).
//   Decodes len/size/burst, generates per-beat FIXED/INCR/WRAP addresses and
//   returns OKAY / SLVERR (illegal burst shape) / DECERR (address outside memory).
//
// Ports
//   clk, rst                    clock (rising edge), asynchronous active-high reset
//   aw* / awvalid / awready     write address channel (awready combinational)
//   wdata/wstrb/wlast/wvalid/wready   write data channel
//   bid/bresp/bvalid/bready     write response channel (registered)
//   ar* / arvalid / arready     read address channel (arready combinational)
//   rid/rdata/rresp/rlast/rvalid/rready  read data channel (registered)
//   Encodings: burst FIXED=00 INCR=01 WRAP=10 RSVD=11; resp OKAY=00 SLVERR=10 DECERR=11.
// ---------------------------------------------------------------------------
module axi4_mem_responder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    MEM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [2:0]            MAX_SIZE = 3'(OFFS);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ONE_A    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WDATA = 2'd1,
        S_WRESP = 2'd2,
        S_RDATA = 2'd3
    } state_t;

    // Address of the beat following 'addr'. Unaligned starts align from beat 1 on.
    function automatic logic [ADDR_WIDTH-1:0] next_beat_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] bytes;
        logic [ADDR_WIDTH-1:0] incr;
        logic [ADDR_WIDTH-1:0] wmask;
        bytes = ONE_A << size;
        incr  = (addr & ~(bytes - ONE_A)) + bytes;
        wmask = (({{(ADDR_WIDTH-8){1'b0}}, len} + ONE_A) << size) - ONE_A;
        case (burst)
            BURST_FIXED: next_beat_addr = addr;
            BURST_WRAP:  next_beat_addr = (addr & ~wmask) | (incr & wmask);
            default:     next_beat_addr = incr;
        endcase
    endfunction

    // Burst shapes that are answered with SLVERR on every beat.
    function automatic logic burst_error(
        input logic [7:0] len,
        input logic [2:0] size,
        input logic [1:0] burst
    );
        logic bad_wrap_len;
        bad_wrap_len = !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
        burst_error  = (size > MAX_SIZE) || (burst == BURST_RSVD) ||
                       ((burst == BURST_WRAP) && bad_wrap_len);
    endfunction

    // Beat address falls outside the backing memory.
    function automatic logic decode_error(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off          = addr - BASE_ADDR;
        decode_error = (addr < BASE_ADDR) || ((off >> OFFS) >= DEPTH_A);
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off        = addr - BASE_ADDR;
        word_index = IDX_W'(off >> OFFS);
    endfunction

    // Response ordering DECERR > SLVERR > OKAY matches the numeric code order.
    function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
        worse = (a > b) ? a : b;
    endfunction

    state_t                state_q, state_d;
    logic                  prio_wr_q, prio_wr_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic                  berr_q, berr_d;
    logic [7:0]            beat_q, beat_d;
    logic [1:0]            wacc_q, wacc_d;
    logic                  bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic                  gnt_ar_s, gnt_aw_s, in_idle_s;
    logic [ADDR_WIDTH-1:0] nxt_addr_s, rd_addr_s;
    logic                  rd_berr_s, rd_dec_s;
    logic [1:0]            rd_resp_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic [1:0]            wr_resp_s;
    logic                  mem_we_s;
    logic [IDX_W-1:0]      mem_idx_s;

    // Address-channel arbitration; readies are held low while in reset.
    always_comb begin
        if (arvalid && awvalid) begin
            gnt_ar_s = !prio_wr_q;
            gnt_aw_s = prio_wr_q;
        end else begin
            gnt_ar_s = arvalid;
            gnt_aw_s = awvalid;
        end
        in_idle_s = (state_q == S_IDLE) && !rst;
    end

    assign arready = in_idle_s && gnt_ar_s;
    assign awready = in_idle_s && gnt_aw_s;
    assign wready  = (state_q == S_WDATA) && !rst;

    // Read beat lookup: beat 0 straight from araddr, later beats from the next address.
    always_comb begin
        nxt_addr_s = next_beat_addr(addr_q, len_q, size_q, burst_q);
        if (state_q == S_IDLE) begin
            rd_addr_s = araddr;
            rd_berr_s = burst_error(arlen, arsize, arburst);
        end else begin
            rd_addr_s = nxt_addr_s;
            rd_berr_s = berr_q;
        end
        rd_dec_s = decode_error(rd_addr_s);
        if (rd_berr_s) begin
            rd_resp_s = RESP_SLVERR;
        end else if (rd_dec_s) begin
            rd_resp_s = RESP_DECERR;
        end else begin
            rd_resp_s = RESP_OKAY;
        end
        if (rd_resp_s != RESP_OKAY) begin
            rd_data_s = '0;
        end else begin
            rd_data_s = mem_q[word_index(rd_addr_s)];
        end
    end

    // Write beat response; a misplaced wlast also makes the beat an error beat.
    always_comb begin
        if (berr_q) begin
            wr_resp_s = RESP_SLVERR;
        end else if (decode_error(addr_q)) begin
            wr_resp_s = RESP_DECERR;
        end else begin
            wr_resp_s = RESP_OKAY;
        end
        if (wlast != (beat_q == len_q)) begin
            wr_resp_s = worse(wr_resp_s, RESP_SLVERR);
        end else begin
            wr_resp_s = wr_resp_s;
        end
        mem_we_s  = wready && wvalid && (wr_resp_s == RESP_OKAY);
        mem_idx_s = word_index(addr_q);
    end

    // Next-state and registered-output logic for the transaction FSM.
    always_comb begin
        state_d   = state_q;
        prio_wr_d = prio_wr_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        berr_d    = berr_q;
        beat_d    = beat_q;
        wacc_d    = wacc_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        case (state_q)
            S_IDLE: begin
                if (arvalid && awvalid) begin
                    prio_wr_d = !prio_wr_q;
                end else begin
                    prio_wr_d = prio_wr_q;
                end
                if (arvalid && gnt_ar_s) begin
                    id_d     = arid;
                    addr_d   = araddr;
                    len_d    = arlen;
                    size_d   = arsize;
                    burst_d  = arburst;
                    berr_d   = rd_berr_s;
                    beat_d   = 8'd0;
                    rvalid_d = 1'b1;
                    rid_d    = arid;
                    rdata_d  = rd_data_s;
                    rresp_d  = rd_resp_s;
                    rlast_d  = (arlen == 8'd0);
                    state_d  = S_RDATA;
                end else if (awvalid && gnt_aw_s) begin
                    id_d    = awid;
                    addr_d  = awaddr;
                    len_d   = awlen;
                    size_d  = awsize;
                    burst_d = awburst;
                    berr_d  = burst_error(awlen, awsize, awburst);
                    beat_d  = 8'd0;
                    wacc_d  = RESP_OKAY;
                    state_d = S_WDATA;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WDATA: begin
                if (wvalid) begin
                    wacc_d = worse(wacc_q, wr_resp_s);
                    addr_d = nxt_addr_s;
                    beat_d = beat_q + 8'd1;
                    if (beat_q == len_q) begin
                        bvalid_d = 1'b1;
                        bid_d    = id_q;
                        bresp_d  = worse(wacc_q, wr_resp_s);
                        state_d  = S_WRESP;
                    end else begin
                        state_d = S_WDATA;
                    end
                end else begin
                    state_d = S_WDATA;
                end
            end
            S_WRESP: begin
                if (bready) begin
                    bvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_WRESP;
                end
            end
            S_RDATA: begin
                if (rready && rlast_q) begin
                    rvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (rready) begin
                    addr_d  = nxt_addr_s;
                    beat_d  = beat_q + 8'd1;
                    rdata_d = rd_data_s;
                    rresp_d = rd_resp_s;
                    rlast_d = ((beat_q + 8'd1) == len_q);
                end else begin
                    state_d = S_RDATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            prio_wr_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= 8'd0;
            size_q    <= 3'd0;
            burst_q   <= 2'd0;
            berr_q    <= 1'b0;
            beat_q    <= 8'd0;
            wacc_q    <= 2'd0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= 2'd0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= 2'd0;
            rlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_wr_q <= prio_wr_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            berr_q    <= berr_d;
            beat_q    <= beat_d;
            wacc_q    <= wacc_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    // Byte-enabled memory write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) begin
                    mem_q[mem_idx_s][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign bvalid = bvalid_q;
    assign bid    = bid_q;
    assign bresp  = bresp_q;
    assign rvalid = rvalid_q;
    assign rid    = rid_q;
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;
    assign rlast  = rlast_q;

endmodule
